// File: rtl/vec_pkg.sv
// Shared vector-datapath definitions: lane geometry, fp16 lane type,
// the VST opcode (shared with decode/ALU) and the store-serializer FSM states.
package vec_pkg;

    localparam int VEC_LANES  = 16;
    localparam int VEC_LANE_W = 16;
    localparam int VEC_ADDR_W = 16;

    typedef logic [VEC_LANE_W-1:0] fp16_t;

    localparam logic [3:0] OP_VST = 4'b0101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } vst_state_e;

endpackage

// File: rtl/lane_find_next.sv
// Combinational priority encoder: remaining lane mask -> {any, lowest set index}.
// Ports: mask_i (LANES), any_o (1), idx_o ($clog2(LANES)).
module lane_find_next #(
    parameter int LANES = 16,
    parameter int IDX_W = $clog2(LANES)
) (
    input  logic [LANES-1:0] mask_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    assign any_o = |mask_i;

    // Scan high to low so the last hit, the lowest set bit, wins.
    always_comb begin
        idx_o = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask_i[i]) idx_o = i[IDX_W-1:0];
        end
    end

endmodule

// File: rtl/vec_store_serializer.sv
// VST writer: captures a 16-lane vector, mask and base address, then writes the
// enabled lanes in ascending order as 16-bit words on the data-memory port.
// Ports: clk, rst_n; start_valid/start_ready + vec_in/lane_mask/base_addr request;
// mem_wr_en/mem_addr/mem_wdata/mem_ready write port; busy, done status.
module vec_store_serializer
    import vec_pkg::*;
#(
    parameter int LANES  = VEC_LANES,
    parameter int LANE_W = VEC_LANE_W,
    parameter int ADDR_W = VEC_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [LANES*LANE_W-1:0] vec_in,
    input  logic [LANES-1:0]        lane_mask,
    input  logic [ADDR_W-1:0]       base_addr,
    output logic                    mem_wr_en,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [LANE_W-1:0]       mem_wdata,
    input  logic                    mem_ready,
    output logic                    busy,
    output logic                    done
);

    localparam int IDX_W = $clog2(LANES);

    vst_state_e              state_q, state_d;
    logic [LANES*LANE_W-1:0] vec_q, vec_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic [LANES-1:0]        rem_q, rem_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [LANE_W-1:0]       wdata_q, wdata_d;
    logic                    done_q, done_d;

    logic [LANES-1:0]        cur_oh;
    logic [LANES-1:0]        enc_in;
    logic                    nxt_any;
    logic [IDX_W-1:0]        nxt_idx;
    logic [LANES*LANE_W-1:0] sel_vec;
    logic [ADDR_W-1:0]       sel_base;
    logic [ADDR_W-1:0]       nxt_addr;
    logic [LANE_W-1:0]       nxt_wdata;

    // In IDLE the encoder looks at the incoming mask so lane selection for the
    // first write happens at accept; in WRITE it looks past the lane on the bus.
    assign cur_oh   = {{(LANES-1){1'b0}}, 1'b1} << idx_q;
    assign enc_in   = (state_q == S_IDLE) ? lane_mask : (rem_q & ~cur_oh);
    assign sel_vec  = (state_q == S_IDLE) ? vec_in : vec_q;
    assign sel_base = (state_q == S_IDLE) ? base_addr : base_q;

    lane_find_next #(
        .LANES(LANES),
        .IDX_W(IDX_W)
    ) u_find (
        .mask_i(enc_in),
        .any_o (nxt_any),
        .idx_o (nxt_idx)
    );

    // Address wraps modulo 2^ADDR_W by truncation.
    assign nxt_addr  = sel_base + {{(ADDR_W-IDX_W){1'b0}}, nxt_idx};
    assign nxt_wdata = sel_vec[int'(nxt_idx)*LANE_W +: LANE_W];

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        base_d  = base_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        wr_en_d = wr_en_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    vec_d  = vec_in;
                    base_d = base_addr;
                    rem_d  = lane_mask;
                    if (nxt_any) begin
                        state_d = S_WRITE;
                        wr_en_d = 1'b1;
                        idx_d   = nxt_idx;
                        addr_d  = nxt_addr;
                        wdata_d = nxt_wdata;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (mem_ready) begin
                    rem_d = enc_in;
                    if (nxt_any) begin
                        idx_d   = nxt_idx;
                        addr_d  = nxt_addr;
                        wdata_d = nxt_wdata;
                    end else begin
                        state_d = S_DONE;
                        wr_en_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                wr_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            base_q  <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            base_q  <= base_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign mem_wr_en   = wr_en_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign done        = done_q;

endmodule
